// File: rtl/common_pkg.sv
// Shared types and constants for the polyphonic sound block.
package common;

  localparam int unsigned SND_DEFAULT_TICK_DIV = 50000;

  // Upper bounds on the per-channel field widths that snd_channel_cfg_t can carry.
  localparam int unsigned SND_COUNT_WIDTH_MAX    = 32;
  localparam int unsigned SND_DURATION_WIDTH_MAX = 32;

  // Note configuration presented to every channel. Narrower instances zero-extend
  // into these fields.
  typedef struct packed {
    logic [SND_COUNT_WIDTH_MAX-1:0]    max_count;
    logic [SND_DURATION_WIDTH_MAX-1:0] duration;
  } snd_channel_cfg_t;

endpackage

// File: rtl/sound_channel.sv
// One square-wave tone channel: phase counter, tone level, remaining note
// length in ticks and a sounding flag.
module sound_channel
  import common::*;
#(
  parameter int unsigned COUNT_WIDTH    = 26,
  parameter int unsigned DURATION_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_async,
  input  logic             en,
  input  logic             load,
  input  logic             stop,
  input  logic             tick,
  input  snd_channel_cfg_t cfg,
  output logic             active,
  output logic             tone
);

  localparam logic [COUNT_WIDTH-1:0]    ONE_C = 1;
  localparam logic [DURATION_WIDTH-1:0] ONE_D = 1;

  logic [COUNT_WIDTH-1:0]    mc_in;
  logic [DURATION_WIDTH-1:0] dur_in;
  logic [COUNT_WIDTH-1:0]    mc_q;
  logic [COUNT_WIDTH-1:0]    counter;
  logic [DURATION_WIDTH-1:0] remaining;

  // Values wider than this instance saturate; the top zero-extends, so this
  // never triggers there and folds away.
  if (COUNT_WIDTH < SND_COUNT_WIDTH_MAX) begin : g_mc_clamp
    assign mc_in = (|cfg.max_count[SND_COUNT_WIDTH_MAX-1:COUNT_WIDTH]) ?
                   '1 : cfg.max_count[COUNT_WIDTH-1:0];
  end else begin : g_mc_full
    assign mc_in = cfg.max_count;
  end

  if (DURATION_WIDTH < SND_DURATION_WIDTH_MAX) begin : g_dur_clamp
    assign dur_in = (|cfg.duration[SND_DURATION_WIDTH_MAX-1:DURATION_WIDTH]) ?
                    '1 : cfg.duration[DURATION_WIDTH-1:0];
  end else begin : g_dur_full
    assign dur_in = cfg.duration;
  end

  // Channel state: stop beats load, load beats expiry, then tone generation.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      mc_q      <= '0;
      counter   <= '0;
      remaining <= '0;
      tone      <= 1'b0;
      active    <= 1'b0;
    end else if (en) begin
      if (stop) begin
        mc_q      <= '0;
        counter   <= '0;
        remaining <= '0;
        tone      <= 1'b0;
        active    <= 1'b0;
      end else if (load) begin
        mc_q      <= mc_in;
        counter   <= '0;
        remaining <= dur_in;
        tone      <= 1'b0;
        active    <= (mc_in != '0);
      end else if (active) begin
        if (tick && (remaining == ONE_D)) begin
          counter   <= '0;
          remaining <= '0;
          tone      <= 1'b0;
          active    <= 1'b0;
        end else begin
          if (tick && (remaining != '0)) begin
            remaining <= remaining - ONE_D;
          end
          if (counter == mc_q) begin
            counter <= '0;
            tone    <= ~tone;
          end else begin
            counter <= counter + ONE_C;
          end
        end
      end else begin
        counter <= '0;
        tone    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/polyphonic_sound.sv
// Multi-channel tone generator: shared duration prescaler, NUM_CHANNELS
// sound_channel instances and a first-order sigma-delta mixer onto one pin.
// COUNT_WIDTH and DURATION_WIDTH are limited to 32 bits by snd_channel_cfg_t.
module polyphonic_sound
  import common::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned COUNT_WIDTH    = 26,
  parameter int unsigned DURATION_WIDTH = 16,
  parameter int unsigned TICK_DIV       = SND_DEFAULT_TICK_DIV
) (
  input  logic                                                   clk,
  input  logic                                                   rst_async,
  input  logic                                                   en,
  input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] ch_sel,
  input  logic [COUNT_WIDTH-1:0]                                 max_count,
  input  logic [DURATION_WIDTH-1:0]                              duration,
  input  logic                                                   latch,
  input  logic                                                   stop_all,
  output logic [NUM_CHANNELS-1:0]                                active,
  output logic                                                   buzzer
);

  localparam int unsigned SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACC_W = $clog2(2 * NUM_CHANNELS);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    ONE_P      = 1;
  localparam logic [ACC_W-1:0] NCH_ACC    = ACC_W'(NUM_CHANNELS);

  logic [PW-1:0]           presc;
  logic                    tick;
  logic [NUM_CHANNELS-1:0] tone;
  snd_channel_cfg_t        cfg;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic [ACC_W-1:0]        level_sum;

  assign tick = en && (presc == PRESC_LAST);

  // Shared prescaler producing one duration tick every TICK_DIV enabled cycles.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + ONE_P;
    end
  end

  // Zero-extend the note fields into the shared configuration record.
  always_comb begin
    cfg = '0;
    cfg.max_count[COUNT_WIDTH-1:0]   = max_count;
    cfg.duration[DURATION_WIDTH-1:0] = duration;
  end

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    sound_channel #(
      .COUNT_WIDTH    (COUNT_WIDTH),
      .DURATION_WIDTH (DURATION_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_async (rst_async),
      .en        (en),
      .load      (latch && (ch_sel == SEL_W'(i))),
      .stop      (stop_all),
      .tick      (tick),
      .cfg       (cfg),
      .active    (active[i]),
      .tone      (tone[i])
    );
  end

  // Count high tone levels and add them into the sigma-delta accumulator.
  always_comb begin
    level_sum = '0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      level_sum = level_sum + ACC_W'(tone[k]);
    end
    acc_next = acc + level_sum;
  end

  // Registered mixer output; disabled cycles hold the accumulator and mute.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      acc    <= '0;
      buzzer <= 1'b0;
    end else if (en) begin
      if (acc_next >= NCH_ACC) begin
        acc    <= acc_next - NCH_ACC;
        buzzer <= 1'b1;
      end else begin
        acc    <= acc_next;
        buzzer <= 1'b0;
      end
    end else begin
      buzzer <= 1'b0;
    end
  end

endmodule

// File: tb/tb_polyphonic_sound.sv
// Self-checking bench for polyphonic_sound (4 channels, tick every 10 cycles).
module tb_polyphonic_sound;

  localparam int unsigned NCH  = 4;
  localparam int unsigned TDIV = 10;
  localparam int unsigned CW   = 26;
  localparam int unsigned DW   = 16;

  logic           clk;
  logic           rst;
  logic           en;
  logic [1:0]     ch_sel;
  logic [CW-1:0]  max_count;
  logic [DW-1:0]  duration;
  logic           latch;
  logic           stop_all;
  logic [NCH-1:0] active;
  logic           buzzer;

  int          total = 0;
  int          bad   = 0;
  int unsigned edge_n;      // enabled rising edges since the last reset
  int          exp_q[$];    // scoreboard of expected per-cycle values
  int          win_q[$];    // scoreboard of expected window counts

  polyphonic_sound #(
    .NUM_CHANNELS   (NCH),
    .COUNT_WIDTH    (CW),
    .DURATION_WIDTH (DW),
    .TICK_DIV       (TDIV)
  ) dut (
    .clk       (clk),
    .rst_async (rst),
    .en        (en),
    .ch_sel    (ch_sel),
    .max_count (max_count),
    .duration  (duration),
    .latch     (latch),
    .stop_all  (stop_all),
    .active    (active),
    .buzzer    (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_n <= 0;
    else if (en) edge_n <= edge_n + 1;
  end

  // Buzzer after enabled edge d (d counted from the load edge) for a lone
  // channel with max_count=7 and a zeroed accumulator: tone high during
  // d=8..15 of each 16, so the accumulator fires at d%16 == 12 and d%16 == 0.
  function automatic bit tone_bz(input int unsigned d);
    return (d >= 12) && (((d % 16) == 12) || ((d % 16) == 0));
  endfunction

  task automatic do_latch(input int unsigned ch, input int unsigned mc,
                          input int unsigned dur, output int unsigned l);
    ch_sel    = ch[1:0];
    max_count = CW'(mc);
    duration  = DW'(dur);
    latch     = 1'b1;
    @(negedge clk);
    latch     = 1'b0;
    l         = edge_n;
  endtask

  task automatic do_stop();
    stop_all = 1'b1;
    @(negedge clk);
    stop_all = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (active !== 4'b0000) begin bad++; $display("FAIL reset_active got=%b want=0000", active); end
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL reset_buzzer got=%b want=0", buzzer); end
    rst = 1'b0;
  endtask

  task automatic test_tone();
    int unsigned l, d;
    int hi1, hi2, e, w;
    hi1 = 0; hi2 = 0;
    do_latch(0, 7, 0, l);
    win_q.push_back(2);
    win_q.push_back(2);
    total++;
    if (active !== 4'b0001) begin bad++; $display("FAIL tone_active got=%b want=0001", active); end
    for (int k = 0; k < 48; k++) begin
      exp_q.push_back(int'(tone_bz(edge_n + 1 - l)));
      @(negedge clk);
      e = exp_q.pop_front();
      d = edge_n - l;
      total++;
      if (buzzer !== e[0]) begin bad++; $display("FAIL tone_wave d=%0d got=%b want=%b", d, buzzer, e[0]); end
      if (d >= 16 && d < 32) hi1 += int'(buzzer);
      if (d >= 32 && d < 48) hi2 += int'(buzzer);
    end
    w = win_q.pop_front();
    total++;
    if (hi1 != w) begin bad++; $display("FAIL tone_window1 got=%0d want=%0d", hi1, w); end
    w = win_q.pop_front();
    total++;
    if (hi2 != w) begin bad++; $display("FAIL tone_window2 got=%0d want=%0d", hi2, w); end
    do_stop();
  endtask

  task automatic test_expiry();
    int unsigned l;
    int at, e, hi;
    bit seen;
    seen = 0; at = -1; hi = 0;
    do_latch(1, 3, 3, l);
    exp_q.push_back(int'((l / TDIV + 3) * TDIV));
    total++;
    if (active[1] !== 1'b1) begin bad++; $display("FAIL expiry_start got=%b want=1", active[1]); end
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (active[1] === 1'b0) begin seen = 1; at = int'(edge_n); end
    end
    e = exp_q.pop_front();
    total++;
    if (!seen || at != e) begin bad++; $display("FAIL expiry_edge got=%0d want=%0d", at, e); end
    repeat (10) begin
      @(negedge clk);
      hi += int'(buzzer);
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL expiry_idle got=%0d want=0", hi); end
  endtask

  task automatic test_latch_on_expiry();
    int unsigned l, l2, e1;
    int at, e;
    bit seen;
    seen = 0; at = -1;
    do_latch(1, 3, 2, l);
    e1 = (l / TDIV + 2) * TDIV;
    for (int k = 0; k < 100 && edge_n < e1 - 1; k++) @(negedge clk);
    do_latch(1, 3, 4, l2);
    exp_q.push_back(int'((l2 / TDIV + 4) * TDIV));
    total++;
    if (active[1] !== 1'b1) begin bad++; $display("FAIL relatch_active got=%b want=1", active[1]); end
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (active[1] === 1'b0) begin seen = 1; at = int'(edge_n); end
    end
    e = exp_q.pop_front();
    total++;
    if (!seen || at != e) begin bad++; $display("FAIL relatch_edge got=%0d want=%0d", at, e); end
  endtask

  task automatic test_stop_priority();
    int unsigned l;
    for (int unsigned i = 0; i < NCH; i++) do_latch(i, 5 + i, 0, l);
    total++;
    if (active !== 4'b1111) begin bad++; $display("FAIL stop_all_on got=%b want=1111", active); end
    stop_all  = 1'b1;
    latch     = 1'b1;
    ch_sel    = 2'd2;
    max_count = CW'(5);
    @(negedge clk);
    stop_all = 1'b0;
    latch    = 1'b0;
    total++;
    if (active !== 4'b0000) begin bad++; $display("FAIL stop_priority got=%b want=0000", active); end
    repeat (2) @(negedge clk);
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL stop_buzzer got=%b want=0", buzzer); end
  endtask

  task automatic test_enable();
    int unsigned l;
    int e;
    bit en_now;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_latch(0, 7, 0, l);
    for (int k = 0; k < 90; k++) begin
      en_now = !(k >= 21 && k < 41);
      en = en_now;
      if (k == 30) begin
        stop_all = 1'b1; latch = 1'b1; ch_sel = 2'd0; max_count = CW'(3);
      end else begin
        stop_all = 1'b0; latch = 1'b0;
      end
      exp_q.push_back(en_now ? int'(tone_bz(edge_n + 1 - l)) : 0);
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if (buzzer !== e[0]) begin bad++; $display("FAIL enable_wave k=%0d got=%b want=%b", k, buzzer, e[0]); end
      if (k == 40) begin
        total++;
        if (active !== 4'b0001) begin bad++; $display("FAIL enable_hold got=%b want=0001", active); end
      end
    end
    en = 1'b1;
    do_latch(1, 0, 5, l);
    total++;
    if (active !== 4'b0001) begin bad++; $display("FAIL zero_count_ch1 got=%b want=0001", active); end
    do_latch(0, 0, 0, l);
    total++;
    if (active !== 4'b0000) begin bad++; $display("FAIL zero_count_ch0 got=%b want=0000", active); end
  endtask

  task automatic test_reset_mid();
    int unsigned l;
    int hi;
    bit act_seen;
    hi = 0; act_seen = 0;
    do_latch(2, 3, 0, l);
    repeat (5) @(negedge clk);
    total++;
    if (active !== 4'b0100) begin bad++; $display("FAIL midreset_pre got=%b want=0100", active); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (active !== 4'b0000) begin bad++; $display("FAIL midreset_active got=%b want=0000", active); end
    total++;
    if (buzzer !== 1'b0) begin bad++; $display("FAIL midreset_buzzer got=%b want=0", buzzer); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      hi += int'(buzzer);
      if (active !== 4'b0000) act_seen = 1;
    end
    total++;
    if (hi != 0) begin bad++; $display("FAIL postreset_buzzer got=%0d want=0", hi); end
    total++;
    if (act_seen) begin bad++; $display("FAIL postreset_active got=1 want=0"); end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b1;
    ch_sel    = '0;
    max_count = '0;
    duration  = '0;
    latch     = 1'b0;
    stop_all  = 1'b0;
    test_reset();
    test_tone();
    test_expiry();
    test_latch_on_expiry();
    test_stop_priority();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/polyphonic_sound.md
POLYPHONIC_SOUND -- requirements
Module: polyphonic_sound

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of independent tone channels (1..8).
REQ-002 SHALL have parameter COUNT_WIDTH, default 26, width of per-channel half-period count (sub-1 Hz at 50 MHz).
REQ-003 SHALL have parameter DURATION_WIDTH, default 16, width of per-channel duration in ticks.
REQ-004 SHALL have parameter TICK_DIV, default 50000, clk cycles per duration tick (1 ms at 50 MHz).
REQ-005 SHALL have port clk, input, 1, single system clock (50 MHz); all logic on rising edge.
REQ-006 SHALL have port rst_async, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1, global run enable; 0 freezes all state.
REQ-008 SHALL have port ch_sel, input, max(1,$clog2(NUM_CHANNELS)), channel targeted by latch.
REQ-009 SHALL have port max_count, input, COUNT_WIDTH, half-period count for selected channel; 0 = silence.
REQ-010 SHALL have port duration, input, DURATION_WIDTH, note length in ticks; 0 = indefinite.
REQ-011 SHALL have port latch, input, 1, single-cycle strobe loading max_count/duration into ch_sel.
REQ-012 SHALL have port stop_all, input, 1, single-cycle strobe silencing every channel.
REQ-013 SHALL have port active, output, NUM_CHANNELS, per-channel sounding flag.
REQ-014 SHALL have port buzzer, output, 1, mixed 1-bit sigma-delta output.

Function
REQ-015 SHALL, on edge with latch=1 and en=1, load channel ch_sel: phase counter=0, tone level=0, remaining=duration, active=(max_count!=0).
REQ-016 SHALL ignore latch when ch_sel >= NUM_CHANNELS.
REQ-017 SHALL, per active channel, increment phase counter each enabled cycle; on reaching max_count, reset counter to 0 and toggle tone level (period 2*(max_count+1) cycles).
REQ-018 SHALL hold inactive channel counter at 0 and tone level at 0.
REQ-019 SHALL run one shared prescaler 0..TICK_DIV-1 while en=1, asserting internal tick on the cycle it equals TICK_DIV-1, then wrapping to 0.
REQ-020 SHALL, on tick, decrement remaining of each active channel with remaining>0; transition 1->0 clears active and tone level on that same edge.
REQ-021 SHALL leave channels with duration=0 active until relatched or stopped.
REQ-022 SHALL give latch priority over tick expiry on the same channel in the same cycle (channel reloads, stays active if max_count!=0).
REQ-023 SHALL give stop_all priority over latch: all channels inactive, counters and remaining cleared.
REQ-024 SHALL mix: s = count of channels with tone level 1 (0..NUM_CHANNELS); acc_next = acc + s; if acc_next >= NUM_CHANNELS then buzzer<=1, acc<=acc_next-NUM_CHANNELS, else buzzer<=0, acc<=acc_next.
REQ-025 SHALL register buzzer (one cycle latency from tone level to mix output).
REQ-026 SHALL, with en=0, hold all counters, prescaler, acc and active unchanged, ignore latch/stop_all, and drive buzzer 0; resume from identical state when en returns to 1.

Reset
REQ-027 SHALL, while rst_async=1, asynchronously force active=0, buzzer=0, acc=0, prescaler=0, all phase counters, tone levels and remaining=0.
REQ-028 SHALL treat reset mid-note as full abort; no stored note survives reset.

Structure
REQ-029 SHALL place typedef snd_channel_cfg_t (max_count, duration) and constant SND_DEFAULT_TICK_DIV in package common.
REQ-030 SHALL implement each channel as sub-module sound_channel (phase counter, tone level, remaining, active), instantiated NUM_CHANNELS times via generate.
REQ-031 SHALL keep prescaler and sigma-delta mixer in polyphonic_sound; no combinational path from inputs to buzzer.

Verification (NUM_CHANNELS=4, TICK_DIV=10 override unless stated)
REQ-032 SHALL cover: ch0 latch max_count=7, duration=0 -> tone period 16 cycles, buzzer high exactly 2 of each 16 cycles in steady state, active=4'b0001.
REQ-033 SHALL cover: latch ch1 max_count=3, duration=3 -> active[1] clears on third tick edge after load, buzzer idle 0 afterwards.
REQ-034 SHALL cover: latch on ch1 in same cycle as its 1->0 expiry -> active[1] stays 1, remaining = new duration.
REQ-035 SHALL cover: ch0-ch3 active, stop_all and latch ch2 max_count=5 same cycle -> active=4'b0000 next cycle.
REQ-036 SHALL cover: en=0 for 20 cycles mid-note -> buzzer 0, counters frozen; after en=1, waveform continues with identical phase; max_count=0 latch -> active bit 0.
REQ-037 SHALL cover: rst_async pulse mid-note (asynchronous, between edges) -> active=0, buzzer=0 immediately, no tone after release until relatched.
